// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch stage with a single outstanding cache request
//             and a 2-entry {pc, instr} buffer toward decode.
//  Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_cache_req,
    output logic [XLEN-1:0] o_cache_addr,
    input  logic [XLEN-1:0] i_cache_data,
    input  logic            i_cache_done,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    input  logic            i_ready
);

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] fifo_pc_q    [2];
    logic [XLEN-1:0] fifo_instr_q [2];
    logic            rd_ptr_q;
    logic [1:0]      count_q;

    logic            w_push;
    logic            w_pop;
    logic            w_wr_ptr;
    logic [1:0]      count_d;

    // A redirect flushes the buffer, so it also suppresses any push or pop.
    assign w_push   = (state_q == WAIT) && i_cache_done && !i_redirect;
    assign w_pop    = (count_q != 2'd0) && i_ready && !i_redirect;
    assign w_wr_ptr = rd_ptr_q ^ count_q[0];

    always_comb begin
        count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    assign o_cache_req  = (state_q != IDLE);
    assign o_cache_addr = (state_q == IDLE) ? pc_q : req_addr_q;
    assign o_valid      = (count_q != 2'd0);
    assign o_instr      = fifo_instr_q[rd_ptr_q];
    assign o_pc         = fifo_pc_q[rd_ptr_q];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            if (i_redirect) begin
                count_q  <= 2'd0;
                rd_ptr_q <= 1'b0;
                pc_q     <= {i_redirect_pc[XLEN-1:2], 2'b00};
            end else begin
                count_q <= count_d;
                if (w_pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                if (w_push) begin
                    fifo_pc_q[w_wr_ptr]    <= req_addr_q;
                    fifo_instr_q[w_wr_ptr] <= i_cache_data;
                    pc_q                   <= req_addr_q + c_pc_step;
                end
            end

            // Issuing only with a free slot guarantees the response always fits.
            case (state_q)
                IDLE: begin
                    if (!i_redirect && (count_q < 2'd2)) begin
                        state_q    <= WAIT;
                        req_addr_q <= pc_q;
                    end
                end
                WAIT: begin
                    if (i_redirect) begin
                        state_q <= i_cache_done ? IDLE : DRAIN;
                    end else if (i_cache_done) begin
                        if (count_d < 2'd2) begin
                            state_q    <= WAIT;
                            req_addr_q <= req_addr_q + c_pc_step;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (i_cache_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(w_push && (count_q == 2'd2)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Scoreboard bench for fetch_unit: cache responder, redirects,
//             back-pressure, address wrap and asynchronous reset.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        o_cache_req;
    logic [31:0] o_cache_addr;
    logic [31:0] i_cache_data  = '0;
    logic        i_cache_done  = 1'b0;
    logic        i_redirect    = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready       = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (c_reset_pc)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_cache_req   (o_cache_req),
        .o_cache_addr  (o_cache_addr),
        .i_cache_data  (i_cache_data),
        .i_cache_done  (i_cache_done),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_ready       (i_ready)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          n_acc    = 0;
    logic [31:0] exp_pc;
    bit          draining;
    int          age;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        exp_pc   = c_reset_pc;
        draining = 1'b0;
        age      = 0;
    endtask

    // One clock cycle: drive inputs, score the cycle, advance to edge+1.
    task automatic cycle(input bit done, input bit redir, input logic [31:0] rpc, input bit rdy);
        entry_t e;
        i_cache_done  = done;
        i_cache_data  = mem_word(o_cache_addr);
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_ready       = rdy;
        check_val("valid", {31'b0, o_valid}, {31'b0, sb_q.size() != 0});
        if (o_valid && rdy && !redir && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val("o_pc", o_pc, e.pc);
            check_val("o_instr", o_instr, e.instr);
        end
        if (o_cache_req && done) begin
            if (draining) begin
                draining = 1'b0;
            end else if (!redir) begin
                check_val("fetch_addr", o_cache_addr, exp_pc);
                e.pc    = exp_pc;
                e.instr = mem_word(exp_pc);
                sb_q.push_back(e);
                exp_pc  = exp_pc + 32'd4;
                n_acc++;
            end
        end else if (o_cache_req && redir) begin
            draining = 1'b1;
        end
        if (redir) begin
            sb_q.delete();
            exp_pc = {rpc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_auto(input int n, input int lat, input bit rdy);
        bit d;
        for (int k = 0; k < n; k++) begin
            if (o_cache_req) begin
                age++;
                d = (age >= lat);
            end else begin
                age = 0;
                d   = 1'b0;
            end
            if (d) age = 0;
            cycle(d, 1'b0, '0, rdy);
        end
    endtask

    task automatic do_reset();
        i_cache_done = 1'b0;
        i_redirect   = 1'b0;
        i_ready      = 1'b0;
        rst          = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int  n0;
        int  lat;
        bit  d;
        bit  rd;
        model_reset();

        #1 rst = 1'b1;
        #1;
        check_val("rst_req",   {31'b0, o_cache_req}, 32'd0);
        check_val("rst_addr",  o_cache_addr, c_reset_pc);
        check_val("rst_valid", {31'b0, o_valid}, 32'd0);
        check_val("rst_instr", o_instr, 32'd0);
        check_val("rst_pc",    o_pc, 32'd0);

        // Back-to-back completions with decode always ready.
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b1);
        check_val("first_req",  {31'b0, o_cache_req}, 32'd1);
        check_val("first_addr", o_cache_addr, c_reset_pc);
        n0 = n_acc;
        run_auto(8, 1, 1'b1);
        check_val("throughput", n_acc - n0, 32'd8);

        // Decode stalled: buffer fills, fetch stops until a pop.
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b0);
        run_auto(2, 1, 1'b0);
        check_val("full_req_off", {31'b0, o_cache_req}, 32'd0);
        run_auto(3, 1, 1'b0);
        check_val("full_req_stay", {31'b0, o_cache_req}, 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check_val("pop_no_issue", {31'b0, o_cache_req}, 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        check_val("third_req",  {31'b0, o_cache_req}, 32'd1);
        check_val("third_addr", o_cache_addr, 32'h8);
        run_auto(8, 1, 1'b1);

        // Redirect while waiting on addr 8, late response discarded.
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b1);
        run_auto(2, 1, 1'b1);
        check_val("wait_addr8", o_cache_addr, 32'h8);
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        check_val("flush_valid", {31'b0, o_valid}, 32'd0);
        check_val("drain_req",   {31'b0, o_cache_req}, 32'd1);
        check_val("drain_hold",  o_cache_addr, 32'h8);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_val("drain_idle", {31'b0, o_cache_req}, 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check_val("redir_req",  {31'b0, o_cache_req}, 32'd1);
        check_val("redir_addr", o_cache_addr, 32'h100);
        run_auto(4, 1, 1'b1);

        // Redirect coinciding with a completion.
        check_val("pre42_req", {31'b0, o_cache_req}, 32'd1);
        cycle(1'b1, 1'b1, 32'h40, 1'b1);
        check_val("drop_valid", {31'b0, o_valid}, 32'd0);
        check_val("drop_req",   {31'b0, o_cache_req}, 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check_val("drop_next_addr", o_cache_addr, 32'h40);
        run_auto(3, 1, 1'b1);

        // Address wrap at the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check_val("wrap_idle_pc", o_cache_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, '0, 1'b0);
        check_val("wrap_req_addr", o_cache_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check_val("wrap_next_addr", o_cache_addr, 32'h0);
        run_auto(6, 1, 1'b1);

        // Asynchronous reset mid-fetch, then a stray completion.
        do_reset();
        cycle(1'b0, 1'b0, '0, 1'b0);
        run_auto(1, 1, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_val("arst_req",   {31'b0, o_cache_req}, 32'd0);
        check_val("arst_addr",  o_cache_addr, c_reset_pc);
        check_val("arst_valid", {31'b0, o_valid}, 32'd0);
        check_val("arst_instr", o_instr, 32'd0);
        check_val("arst_pc",    o_pc, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b1, 1'b0, '0, 1'b0);
        check_val("restart_req",   {31'b0, o_cache_req}, 32'd1);
        check_val("restart_addr",  o_cache_addr, c_reset_pc);
        check_val("restart_valid", {31'b0, o_valid}, 32'd0);
        run_auto(4, 1, 1'b1);

        // Random latency, back-pressure and redirects.
        do_reset();
        lat = 1;
        for (int k = 0; k < 400; k++) begin
            if (o_cache_req) begin
                age++;
                d = (age >= lat);
            end else begin
                age = 0;
                d   = 1'b0;
            end
            if (d) begin
                age = 0;
                lat = $urandom_range(1, 3);
            end
            rd = ($urandom_range(0, 11) == 0);
            cycle(d, rd, $urandom(), bit'($urandom_range(0, 1)));
        end
        run_auto(10, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
